// File: rtl/prog_fetch.sv
// Instruction fetch for picoMIPS: owns the PC, captures ROM data into the IR
// and hands it to the decoder over valid/ready, taking redirects with one bubble.
module prog_fetch #(
  parameter int P_SIZE = 5,
  parameter int I_SIZE = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              en,
  output logic [P_SIZE-1:0] address,
  input  logic [I_SIZE-1:0] I,
  output logic [I_SIZE-1:0] ir,
  output logic [P_SIZE-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_en,
  input  logic [P_SIZE-1:0] branch_off,
  input  logic              jump_en,
  input  logic [P_SIZE-1:0] jump_addr
);

  typedef struct packed {
    logic              vld;
    logic [P_SIZE-1:0] tgt;
  } redir_t;

  logic [P_SIZE-1:0] pc;
  logic              consume;
  logic              slot;
  redir_t            rd;

  assign address = pc;
  assign consume = ir_valid & ir_ready;
  assign slot    = ~ir_valid | ir_ready;

  // Redirect only counts for the instruction actually leaving the IR; jump beats branch.
  always_comb begin
    rd.vld = consume & (jump_en | branch_en);
    rd.tgt = jump_en ? jump_addr : ir_pc + branch_off;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (rd.vld) begin
      // Flush the wrong-path fetch; IR contents are left stale but invalid.
      pc       <= rd.tgt;
      ir_valid <= 1'b0;
    end else if (en && slot) begin
      ir       <= I;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      pc       <= pc + P_SIZE'(1);
    end else if (consume) begin
      ir_valid <= 1'b0;
    end
  end

endmodule
